// File: rtl/dcache_miss_ctrl.sv
// rtl/dcache_miss_ctrl.sv - direct-mapped data cache miss controller (tag/valid/dirty, write-back, refill)
module dcache_miss_ctrl #(
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 5,
    parameter int TAG_W    = 32 - INDEX_W - OFFSET_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               p1_req_i,
    input  logic               p1_write_i,
    input  logic [31:0]        p1_addr_i,
    output logic               hit_o,
    output logic               stall_o,
    output logic [INDEX_W-1:0] sram_index_o,
    output logic               sram_we_o,
    output logic               sram_fill_o,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [31:0]        mem_addr_o,
    input  logic               mem_ack_i
);
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   tagmem [LINES];
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               victim_dirty;
    logic               store_hit;
    logic               fill_now;
    logic               unused_offset;

    assign idx           = p1_addr_i[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign tag           = p1_addr_i[31:OFFSET_W+INDEX_W];
    assign unused_offset = ^p1_addr_i[OFFSET_W-1:0];
    assign hit           = valid_q[idx] && (tagmem[idx] == tag);
    assign victim_dirty  = valid_q[idx] && dirty_q[idx];
    assign store_hit     = (state_q == IDLE) && p1_req_i && p1_write_i && hit;
    assign fill_now      = (state_q == ALLOCATE) && mem_ack_i;
    assign sram_index_o  = idx;

    // State register; reset drops straight to IDLE so the memory request falls immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Valid/dirty bookkeeping: refill installs a clean line, a store hit marks it dirty.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_now) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag array needs no reset: it is only trusted where the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (fill_now) begin
            tagmem[idx] <= tag;
        end
    end

    // Next-state and output decode; every output is forced low while reset is held.
    always_comb begin
        state_d      = state_q;
        hit_o        = 1'b0;
        stall_o      = 1'b0;
        sram_we_o    = 1'b0;
        sram_fill_o  = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        case (state_q)
            IDLE: begin
                hit_o     = p1_req_i && hit;
                stall_o   = p1_req_i && !hit;
                sram_we_o = store_hit;
                if (p1_req_i && !hit) begin
                    state_d = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                stall_o      = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tagmem[idx], idx, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                stall_o      = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, {OFFSET_W{1'b0}}};
                sram_we_o    = mem_ack_i;
                sram_fill_o  = mem_ack_i;
                if (mem_ack_i) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                stall_o = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!rst_i) begin
            hit_o        = 1'b0;
            stall_o      = 1'b0;
            sram_we_o    = 1'b0;
            sram_fill_o  = 1'b0;
            mem_enable_o = 1'b0;
            mem_write_o  = 1'b0;
            mem_addr_o   = '0;
        end
    end
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb/tb_dcache_miss_ctrl.sv - scoreboard bench for dcache_miss_ctrl
module tb_dcache_miss_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        p1_req_i = 1'b0;
    logic        p1_write_i = 1'b0;
    logic [31:0] p1_addr_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        hit_o, stall_o, sram_we_o, sram_fill_o;
    logic        mem_enable_o, mem_write_o;
    logic [4:0]  sram_index_o;
    logic [31:0] mem_addr_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic        hit, stall, we, fill, men, mwr;
        logic [31:0] maddr;
        logic [4:0]  idx;
    } exp_t;

    exp_t exp_q[$];

    dcache_miss_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p1_req_i     (p1_req_i),
        .p1_write_i   (p1_write_i),
        .p1_addr_i    (p1_addr_i),
        .hit_o        (hit_o),
        .stall_o      (stall_o),
        .sram_index_o (sram_index_o),
        .sram_we_o    (sram_we_o),
        .sram_fill_o  (sram_fill_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compares the DUT outputs against each queued expectation mid-cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk(e.nm, "hit",   {31'd0, hit_o},        {31'd0, e.hit});
                chk(e.nm, "stall", {31'd0, stall_o},      {31'd0, e.stall});
                chk(e.nm, "we",    {31'd0, sram_we_o},    {31'd0, e.we});
                chk(e.nm, "fill",  {31'd0, sram_fill_o},  {31'd0, e.fill});
                chk(e.nm, "men",   {31'd0, mem_enable_o}, {31'd0, e.men});
                chk(e.nm, "mwr",   {31'd0, mem_write_o},  {31'd0, e.mwr});
                chk(e.nm, "maddr", mem_addr_o,            e.maddr);
                chk(e.nm, "idx",   {27'd0, sram_index_o}, {27'd0, e.idx});
            end
        end
    end

    // One cycle of stimulus plus its hand-computed expected outputs.
    task automatic cyc(input logic rst, input logic req, input logic wr, input logic [31:0] addr,
                       input logic ack, input string nm,
                       input logic e_hit, input logic e_stall, input logic e_we, input logic e_fill,
                       input logic e_men, input logic e_mwr, input logic [31:0] e_maddr);
        exp_t e;
        rst_i      = rst;
        p1_req_i   = req;
        p1_write_i = wr;
        p1_addr_i  = addr;
        mem_ack_i  = ack;
        e.nm = nm; e.hit = e_hit; e.stall = e_stall; e.we = e_we; e.fill = e_fill;
        e.men = e_men; e.mwr = e_mwr; e.maddr = e_maddr; e.idx = addr[9:5];
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        @(posedge clk_i);
        #1;
        //   rst req wr addr          ack name          hit stl we fil men mwr maddr
        cyc(0, 1, 0, 32'h0000_0040, 0, "reset_out",    0, 0, 0, 0, 0, 0, 32'h0);
        // cold load 0x40, ack delay 3
        cyc(1, 1, 0, 32'h0000_0040, 0, "cold_miss",    0, 1, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0000_0040, 0, "cold_alloc1",  0, 1, 0, 0, 1, 0, 32'h40);
        cyc(1, 1, 0, 32'h0000_0040, 0, "cold_alloc2",  0, 1, 0, 0, 1, 0, 32'h40);
        cyc(1, 1, 0, 32'h0000_0040, 1, "cold_ack",     0, 1, 1, 1, 1, 0, 32'h40);
        cyc(1, 1, 0, 32'h0000_0040, 0, "cold_refill",  0, 1, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0000_0040, 0, "cold_hit",     1, 0, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0000_0044, 0, "rpt_hit",      1, 0, 0, 0, 0, 0, 32'h0);
        // store hit then conflicting load forces write-back
        cyc(1, 1, 1, 32'h0000_0040, 0, "store_hit",    1, 0, 1, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0000_0440, 0, "dirty_miss",   0, 1, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0000_0440, 0, "wb1",          0, 1, 0, 0, 1, 1, 32'h40);
        cyc(1, 1, 0, 32'h0000_0440, 1, "wb_ack",       0, 1, 0, 0, 1, 1, 32'h40);
        cyc(1, 1, 0, 32'h0000_0440, 0, "alloc440",     0, 1, 0, 0, 1, 0, 32'h440);
        cyc(1, 1, 0, 32'h0000_0440, 1, "alloc440_ack", 0, 1, 1, 1, 1, 0, 32'h440);
        cyc(1, 1, 0, 32'h0000_0440, 0, "refill440",    0, 1, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0000_0440, 0, "hit440",       1, 0, 0, 0, 0, 0, 32'h0);
        // clean victim: straight to allocate, minimum dwell, spurious ack in refill
        cyc(1, 1, 0, 32'h0000_0840, 1, "clean_miss",   0, 1, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0000_0840, 1, "alloc840_ack", 0, 1, 1, 1, 1, 0, 32'h840);
        cyc(1, 1, 0, 32'h0000_0840, 1, "refill_spur",  0, 1, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0000_0840, 0, "hit840",       1, 0, 0, 0, 0, 0, 32'h0);
        // spurious acks in idle
        cyc(1, 0, 0, 32'h0000_0840, 1, "idle_spur",    0, 0, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0000_0840, 1, "idle_spur_hit",1, 0, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0000_0840, 0, "still_hit",    1, 0, 0, 0, 0, 0, 32'h0);
        // reset in allocate before the ack
        cyc(1, 1, 0, 32'h0000_0040, 0, "rst_miss",     0, 1, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0000_0040, 0, "rst_alloc",    0, 1, 0, 0, 1, 0, 32'h40);
        cyc(0, 1, 0, 32'h0000_0040, 1, "rst_async",    0, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 1, 0, 32'h0000_0040, 0, "rst_hold",     0, 0, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0000_0040, 0, "post_rst_miss",0, 1, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0000_0040, 1, "post_rst_ack", 0, 1, 1, 1, 1, 0, 32'h40);
        cyc(1, 1, 0, 32'h0000_0040, 0, "post_rst_ref", 0, 1, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0000_0040, 0, "post_rst_hit", 1, 0, 0, 0, 0, 0, 32'h0);
        cyc(1, 0, 0, 32'h0000_0000, 0, "quiet",        0, 0, 0, 0, 0, 0, 32'h0);
        @(posedge clk_i);
        #1;
        chk("scoreboard", "drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcache_miss_ctrl.md
# dcache_miss_ctrl

Miss-handling controller for the direct-mapped (one-way) data cache. It owns the tag, valid and dirty arrays and classifies each MEM-stage access as hit or miss. On a miss it sequences the write-back of a dirty victim line and the refill from memory, and it drives the global `stall_o` that freezes every pipeline register, including MEM/WB, through their `stall_i` inputs. The data SRAM is external; this block only drives its index, write-enable and fill-select.

## Interface
Parameters:
- `INDEX_W`, default 5: line index width (2^INDEX_W lines).
- `OFFSET_W`, default 5: byte offset width (32-byte lines).
- `TAG_W`, default 32-INDEX_W-OFFSET_W: stored tag width.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `p1_req_i`  in  1  MEM-stage load/store valid.
- `p1_write_i`  in  1  1 = store, 0 = load.
- `p1_addr_i`  in  32  byte address.
- `hit_o`  out  1  current request hits (IDLE only).
- `stall_o`  out  1  freeze all pipeline registers.
- `sram_index_o`  out  INDEX_W  data SRAM line index, equal to `p1_addr_i[OFFSET_W+INDEX_W-1:OFFSET_W]`.
- `sram_we_o`  out  1  data SRAM write strobe.
- `sram_fill_o`  out  1  1 = SRAM write data is the memory line; 0 = the store merge.
- `mem_enable_o`  out  1  memory request valid.
- `mem_write_o`  out  1  1 = write-back, 0 = line read.
- `mem_addr_o`  out  32  line-aligned memory address (low OFFSET_W bits zero).
- `mem_ack_i`  in  1  one-cycle completion pulse from memory.

## Operation
- State register values: IDLE, WRITEBACK, ALLOCATE, REFILL. The reset value is IDLE.
- `idx` and `tag` are the index and tag fields of `p1_addr_i`. A hit is defined as `valid[idx] && tagmem[idx]==tag`.
- IDLE:
  - `hit_o = p1_req_i && hit`.
  - On a hit store: `sram_we_o=1`, `sram_fill_o=0`, and `dirty[idx]<=1` at the clock edge.
  - On a miss (`p1_req_i && !hit`) with `valid && dirty` set on the victim: go to WRITEBACK. Otherwise go to ALLOCATE.
- WRITEBACK:
  - Outputs: `mem_enable_o=1`, `mem_write_o=1`, `mem_addr_o={tagmem[idx], idx, 0}`.
  - Held until `mem_ack_i`, then go to ALLOCATE.
- ALLOCATE:
  - Outputs: `mem_enable_o=1`, `mem_write_o=0`, `mem_addr_o={tag, idx, 0}`.
  - On `mem_ack_i`, in the same cycle: `sram_we_o=1` and `sram_fill_o=1`.
  - At the same edge: `tagmem[idx]<=tag`, `valid<=1`, `dirty<=0`, and go to REFILL.
- REFILL: one cycle with no memory or SRAM activity, then go to IDLE. In IDLE the held request re-looks-up and hits. A store sets dirty at that point.
- `stall_o = (state!=IDLE) || (p1_req_i && !hit)`. It is combinational, so it is asserted in the same cycle the miss is seen.
- `mem_*` outputs are decoded from the state register only. Outside WRITEBACK and ALLOCATE they are all 0.
- `mem_ack_i` is ignored outside WRITEBACK and ALLOCATE.
- If `p1_req_i` drops while the controller is busy, the controller does not abort. The sequence finishes and the controller returns to IDLE.
- Requests are assumed stable while `stall_o=1`, because the pipeline is frozen.

## Timing
- Reset (asynchronous, active-low): state goes to IDLE and all valid and dirty bits clear. At the same time every output goes to 0, except `sram_index_o`, which follows the address.
- Reset asserted mid-sequence: `mem_enable_o` falls without waiting for a clock edge. Any pending `mem_ack_i` is discarded.
- Hit: zero added latency. `stall_o` stays 0.
- Clean miss detected in cycle 0, with the memory ack in cycle A, where A ≥ 1 (ALLOCATE is entered in cycle 1):
  - REFILL in cycle A+1.
  - IDLE with a hit in cycle A+2.
  - `stall_o` is 1 in cycles 0 to A+1.
- Dirty miss: WRITEBACK runs from cycle 1 until its ack in cycle W. ALLOCATE follows from W+1 until its ack.
- An ack in the same cycle the request first asserts is legal. The minimum ALLOCATE dwell is one cycle.

## Test plan
- Cold load to 0x0000_0040 after reset:
  - Cycle 0: `stall_o=1`.
  - ALLOCATE: `mem_addr_o=0x40`, `mem_write_o=0`.
  - Ack at delay 3: fill strobe on the ack cycle, REFILL, then `hit_o=1` and `stall_o=0` two cycles after the ack.
- Repeat load to 0x0000_0044: hit, `stall_o=0`, no `mem_enable_o`.
- Store to 0x0000_0040 (hit): `sram_we_o=1`, `sram_fill_o=0`. Then load 0x0000_0440, which maps to the same index:
  - WRITEBACK to `mem_addr_o=0x40`, `mem_write_o=1`.
  - Then ALLOCATE to 0x440 with a read.
- Load 0x0000_0840 after the clean line at 0x440: no WRITEBACK, straight to ALLOCATE with a read.
- Spurious `mem_ack_i` pulses in IDLE and REFILL: no state change, no SRAM write.
- Reset asserted in ALLOCATE before the ack: `mem_enable_o=0` immediately. After release, a load to 0x40 misses again because valid was cleared.
